riscv_fetch: RTL and testbench
==============================

# riscv_fetch

Instruction-fetch stage of the RV32I core. Owns the program counter, drives the word address into the instruction memory, captures the combinationally-returned instruction into an IF/ID output register, and hands it to decode over a valid/ready handshake. Branch/jump redirects from execute flush the stage and restart fetch at the target.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value after reset; must be 4-byte aligned.
- Widths come from `riscv_configs.v`: `XLEN` (32) and `IMEM_ADDR_BIT` (byte-address bits of instruction memory).

Ports:
- `i_clk`  in  1  core clock; all state updates on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_redirect_en`  in  1  redirect request from execute (taken branch/jump).
- `i_redirect_pc`  in  XLEN  redirect target byte address.
- `o_imem_addr`  out  IMEM_ADDR_BIT-2  word address to instruction memory, equal to `pc[IMEM_ADDR_BIT-1:2]`.
- `i_imem_data`  in  XLEN  instruction word, combinational from memory for `o_imem_addr`.
- `o_if_valid`  out  1  output register holds a valid instruction.
- `i_if_ready`  in  1  decode accepts the instruction this cycle.
- `o_if_instr`  out  XLEN  fetched instruction.
- `o_if_pc`  out  XLEN  byte address of `o_if_instr`.
- `o_fetch_err`  out  1  misaligned-redirect halt indicator (see Configuration).

## Operation
- State: `pc` (XLEN), output register {`valid`, `instr`, `ipc`}, FSM {RUN, HALT}.
- Reset: `pc`=RESET_PC, `o_if_valid`=0, `o_if_instr`=0, `o_if_pc`=0, `o_fetch_err`=0, state=RUN. Reset overrides every other input.
- `o_imem_addr` is driven from the `pc` register only (no combinational path from inputs).
- Load condition in RUN: `load = !o_if_valid || i_if_ready`.
- Priority per edge in RUN: (1) redirect, (2) load, (3) hold.
- Redirect: `pc` <= `i_redirect_pc`; `o_if_valid` <= 0; held or in-flight instruction discarded, even if `i_if_ready`=1 in the same cycle (decode is flushed by the same redirect).
- Load: `o_if_instr` <= `i_imem_data`; `o_if_pc` <= `pc`; `o_if_valid` <= 1; `pc` <= `pc`+4.
- Hold (`o_if_valid`=1, `i_if_ready`=0): `pc`, `o_if_instr`, `o_if_pc`, `o_if_valid` unchanged.
- PC arithmetic modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0. `o_imem_addr` truncation wraps within memory.
- HALT: `o_if_valid`=0, `pc` frozen, redirects and `i_if_ready` ignored; exit only by reset.

## Timing
- Fetch throughput: one instruction per cycle while `i_if_ready`=1.
- Reset released before edge E0: first instruction (RESET_PC) valid after E0 (one empty cycle after reset).
- Redirect sampled at edge E: bubble cycle after E (`o_if_valid`=0), target instruction valid after E+1. Redirect penalty: 1 cycle in this stage.
- Output stability: while `o_if_valid`=1 and `i_if_ready`=0, `o_if_instr`/`o_if_pc` must not change.
- Back-to-back redirects: each restarts fetch; only the last target is fetched.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined: redirect with `i_redirect_pc[1:0]`!=0 moves FSM to HALT at that edge; `o_fetch_err` <= 1 (sticky until reset), `o_if_valid` <= 0, `pc` keeps its prior value.
- Not defined: `i_redirect_pc[1:0]` ignored (target forced to `{i_redirect_pc[XLEN-1:2],2'b00}`); FSM never leaves RUN; `o_fetch_err` tied 0.

## Test plan
- Reset, `i_if_ready`=1 constantly, memory word i = 0x1000+i -> `o_if_pc` 0,4,8,... with `o_if_instr` 0x1000,0x1001,... on consecutive cycles, first valid one cycle after reset release.
- Hold `i_if_ready`=0 for 3 cycles at pc 0x8 -> `o_if_instr`/`o_if_pc`=0x1002/0x8 stable, `o_imem_addr` stays 3; release -> 0xC next.
- Redirect to 0x40 while stalled on 0x8 -> 0x8 dropped, one bubble, then `o_if_pc`=0x40, instr=0x1010.
- `RESET_PC`=32'hFFFF_FFF8, ready=1 -> `o_if_pc` FFFF_FFF8, FFFF_FFFC, 0x0.
- Redirect to 0x42 with macro -> `o_fetch_err`=1, valid stays 0, later redirect to 0x40 ignored, reset clears; without macro -> fetch resumes at 0x40.
- Assert `i_rst` mid-stream with redirect asserted -> next state equals reset values, pc=RESET_PC.

Source files
------------

// File: rtl/riscv_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_fetch
//  Description : Instruction-fetch stage of the RV32I core. Owns the program
//                counter, presents a word address to the instruction memory,
//                captures the combinational memory reply into an IF/ID output
//                register and hands it to decode over a valid/ready handshake.
//                Redirects from execute flush the stage and restart fetch at
//                the target address.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    XLEN           data / address width (32 for RV32I)
//    IMEM_ADDR_BIT  byte-address bits of the instruction memory
//    RESET_PC       PC after reset (must be 4-byte aligned)
//  Ports
//    i_clk          core clock, rising edge
//    i_rst          synchronous active-high reset
//    i_redirect_en  taken branch / jump from execute
//    i_redirect_pc  redirect target byte address
//    o_imem_addr    word address to instruction memory (pc[IMEM_ADDR_BIT-1:2])
//    i_imem_data    instruction word for o_imem_addr (combinational)
//    o_if_valid     output register holds a valid instruction
//    i_if_ready     decode accepts the instruction this cycle
//    o_if_instr     fetched instruction
//    o_if_pc        byte address of o_if_instr
//    o_fetch_err    sticky misaligned-redirect halt flag
//  Build option
//    FETCH_MISALIGN_CHK_EN  when defined, a misaligned redirect halts the
//                           stage and raises o_fetch_err until reset; when not
//                           defined, the low two target bits are ignored.
// ============================================================================
module riscv_fetch #(
    parameter int               XLEN          = 32,
    parameter int               IMEM_ADDR_BIT = 16,
    parameter logic [XLEN-1:0]  RESET_PC      = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_redirect_en,
    input  logic [XLEN-1:0]           i_redirect_pc,
    output logic [IMEM_ADDR_BIT-3:0]  o_imem_addr,
    input  logic [XLEN-1:0]           i_imem_data,
    output logic                      o_if_valid,
    input  logic                      i_if_ready,
    output logic [XLEN-1:0]           o_if_instr,
    output logic [XLEN-1:0]           o_if_pc,
    output logic                      o_fetch_err
);

    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [XLEN-1:0]   r_instr;
    logic [XLEN-1:0]   w_instr_nxt;
    logic [XLEN-1:0]   r_ipc;
    logic [XLEN-1:0]   w_ipc_nxt;
    logic              w_load;
    logic              w_misaligned;
    logic              r_err;
    logic              w_err_nxt;

    // A new word may enter the output register when it is empty or drained.
    assign w_load = !r_valid || i_if_ready;

`ifdef FETCH_MISALIGN_CHK_EN
    assign w_misaligned = (i_redirect_pc[1:0] != 2'b00);
`else
    // Low target bits are dropped instead of checked.
    assign w_misaligned = 1'b0;
    logic w_unused_redirect_lsbs;
    assign w_unused_redirect_lsbs = ^i_redirect_pc[1:0];
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_instr_nxt = r_instr;
        w_ipc_nxt   = r_ipc;
        w_err_nxt   = r_err;

        case (r_state)
            ST_RUN: begin
                if (i_redirect_en) begin
                    // Redirect wins over a handshake in the same cycle: the
                    // held word belongs to the flushed path.
                    w_valid_nxt = 1'b0;
                    if (w_misaligned) begin
                        w_state_nxt = ST_HALT;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_pc_nxt = {i_redirect_pc[XLEN-1:2], 2'b00};
                    end
                end else if (w_load) begin
                    w_instr_nxt = i_imem_data;
                    w_ipc_nxt   = r_pc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pc + c_PC_STEP;
                end
            end
            ST_HALT: begin
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_ipc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_instr <= w_instr_nxt;
            r_ipc   <= w_ipc_nxt;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end
    assign o_fetch_err = r_err;
`else
    assign r_err       = 1'b0;
    assign o_fetch_err = 1'b0;
    logic w_unused_err_nxt;
    assign w_unused_err_nxt = w_err_nxt;
`endif

    // Memory address comes straight from the PC register; upper PC bits
    // beyond the memory size simply wrap.
    assign o_imem_addr = r_pc[IMEM_ADDR_BIT-1:2];
    assign o_if_valid  = r_valid;
    assign o_if_instr  = r_instr;
    assign o_if_pc     = r_ipc;

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_fetch
//  Description : Self-checking bench for riscv_fetch. Two instances share the
//                control inputs: one resets to 0, one to 32'hFFFF_FFF8 to
//                exercise PC wrap. A directed vector table covers the main
//                scenarios, then random traffic is compared against a
//                behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_fetch;

    localparam int AW = 16;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ren;
    logic [31:0] rpc;
    logic        rdy;

    logic [AW-3:0] addr_a, addr_b;
    logic [31:0]   data_a, data_b, instr_a, instr_b, ipc_a, ipc_b;
    logic          valid_a, valid_b, err_a, err_b;

    // Memory image: word i holds 0x1000 + i.
    assign data_a = 32'h1000 + 32'(addr_a);
    assign data_b = 32'h1000 + 32'(addr_b);

    riscv_fetch #(.XLEN(32), .IMEM_ADDR_BIT(AW), .RESET_PC(32'h0000_0000)) u_a (
        .i_clk(clk), .i_rst(rst), .i_redirect_en(ren), .i_redirect_pc(rpc),
        .o_imem_addr(addr_a), .i_imem_data(data_a), .o_if_valid(valid_a),
        .i_if_ready(rdy), .o_if_instr(instr_a), .o_if_pc(ipc_a), .o_fetch_err(err_a)
    );

    riscv_fetch #(.XLEN(32), .IMEM_ADDR_BIT(AW), .RESET_PC(32'hFFFF_FFF8)) u_b (
        .i_clk(clk), .i_rst(rst), .i_redirect_en(ren), .i_redirect_pc(rpc),
        .o_imem_addr(addr_b), .i_imem_data(data_b), .o_if_valid(valid_b),
        .i_if_ready(rdy), .o_if_instr(instr_b), .o_if_pc(ipc_b), .o_fetch_err(err_b)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc[2], m_instr[2], m_ipc[2];
    logic        m_valid[2], m_halt[2], m_err[2];

    function automatic logic [31:0] reset_pc_of(input int k);
        return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'h1000 + ((pc % 32'(1 << AW)) / 4);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pc[k] = reset_pc_of(k); m_valid[k] = 0; m_instr[k] = 0;
                m_ipc[k] = 0; m_err[k] = 0; m_halt[k] = 0;
            end else if (m_halt[k]) begin
                m_valid[k] = 0;
            end else if (ren) begin
                m_valid[k] = 0;
                if (CHK && (rpc % 4) != 0) begin
                    m_halt[k] = 1; m_err[k] = 1;
                end else begin
                    m_pc[k] = rpc - (rpc % 4);
                end
            end else if (!m_valid[k] || rdy) begin
                m_instr[k] = mem_word(m_pc[k]);
                m_ipc[k]   = m_pc[k];
                m_valid[k] = 1;
                m_pc[k]    = m_pc[k] + 4;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step_and_check(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, " a.valid"}, 32'(valid_a), 32'(m_valid[0]));
        chk({tag, " a.instr"}, instr_a, m_instr[0]);
        chk({tag, " a.pc"},    ipc_a,   m_ipc[0]);
        chk({tag, " a.addr"},  32'(addr_a), (m_pc[0] % 32'(1 << AW)) / 4);
        chk({tag, " a.err"},   32'(err_a), 32'(m_err[0]));
        chk({tag, " b.valid"}, 32'(valid_b), 32'(m_valid[1]));
        chk({tag, " b.instr"}, instr_b, m_instr[1]);
        chk({tag, " b.pc"},    ipc_b,   m_ipc[1]);
        chk({tag, " b.addr"},  32'(addr_b), (m_pc[1] % 32'(1 << AW)) / 4);
        chk({tag, " b.err"},   32'(err_b), 32'(m_err[1]));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          ren;
        logic [31:0] rpc;
        bit          rdy;
        bit          ev;
        logic [31:0] eipc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
        bit          eerr;
        bit          cb;
        logic [31:0] ebpc;
    } vec_t;

    function automatic vec_t mk(bit r, bit re, logic [31:0] rp, bit rd, bit v,
                                logic [31:0] ip, logic [31:0] ins, logic [31:0] ad,
                                bit er, bit cb, logic [31:0] bp);
        vec_t t;
        t.rst = r; t.ren = re; t.rpc = rp; t.rdy = rd; t.ev = v; t.eipc = ip;
        t.einstr = ins; t.eaddr = ad; t.eerr = er; t.cb = cb; t.ebpc = bp;
        return t;
    endfunction

    vec_t tv[22];

    initial begin
        //          rst ren rpc      rdy  v  ipc      instr     addr   err cb bpc
        tv[0]  = mk(1, 0, 32'h0,   0,   0, 32'h0,   32'h0,    32'h0,  0, 0, 32'h0);
        tv[1]  = mk(0, 0, 32'h0,   1,   1, 32'h0,   32'h1000, 32'h1,  0, 1, 32'hFFFF_FFF8);
        tv[2]  = mk(0, 0, 32'h0,   1,   1, 32'h4,   32'h1001, 32'h2,  0, 1, 32'hFFFF_FFFC);
        tv[3]  = mk(0, 0, 32'h0,   1,   1, 32'h8,   32'h1002, 32'h3,  0, 1, 32'h0);
        tv[4]  = mk(0, 0, 32'h0,   0,   1, 32'h8,   32'h1002, 32'h3,  0, 0, 32'h0);
        tv[5]  = mk(0, 0, 32'h0,   0,   1, 32'h8,   32'h1002, 32'h3,  0, 0, 32'h0);
        tv[6]  = mk(0, 0, 32'h0,   0,   1, 32'h8,   32'h1002, 32'h3,  0, 0, 32'h0);
        tv[7]  = mk(0, 0, 32'h0,   1,   1, 32'hC,   32'h1003, 32'h4,  0, 0, 32'h0);
        tv[8]  = mk(1, 0, 32'h0,   0,   0, 32'h0,   32'h0,    32'h0,  0, 0, 32'h0);
        tv[9]  = mk(0, 0, 32'h0,   1,   1, 32'h0,   32'h1000, 32'h1,  0, 0, 32'h0);
        tv[10] = mk(0, 0, 32'h0,   1,   1, 32'h4,   32'h1001, 32'h2,  0, 0, 32'h0);
        tv[11] = mk(0, 0, 32'h0,   1,   1, 32'h8,   32'h1002, 32'h3,  0, 0, 32'h0);
        tv[12] = mk(0, 0, 32'h0,   0,   1, 32'h8,   32'h1002, 32'h3,  0, 0, 32'h0);
        tv[13] = mk(0, 1, 32'h40,  0,   0, 32'h8,   32'h1002, 32'h10, 0, 0, 32'h0);
        tv[14] = mk(0, 0, 32'h0,   1,   1, 32'h40,  32'h1010, 32'h11, 0, 0, 32'h0);
        tv[15] = mk(0, 1, 32'h80,  1,   0, 32'h40,  32'h1010, 32'h20, 0, 0, 32'h0);
        tv[16] = mk(0, 1, 32'h100, 1,   0, 32'h40,  32'h1010, 32'h40, 0, 0, 32'h0);
        tv[17] = mk(0, 0, 32'h0,   1,   1, 32'h100, 32'h1040, 32'h41, 0, 0, 32'h0);
        tv[18] = mk(0, 1, 32'h42,  1,   0, 32'h100, 32'h1040, CHK ? 32'h41 : 32'h10, CHK, 0, 32'h0);
        tv[19] = mk(0, 1, 32'h40,  1,   0, 32'h100, 32'h1040, CHK ? 32'h41 : 32'h10, CHK, 0, 32'h0);
        tv[20] = mk(0, 0, 32'h0,   1,   !CHK, CHK ? 32'h100 : 32'h40,
                    CHK ? 32'h1040 : 32'h1010, CHK ? 32'h41 : 32'h11, CHK, 0, 32'h0);
        tv[21] = mk(1, 1, 32'h80,  1,   0, 32'h0,   32'h0,    32'h0,  0, 0, 32'h0);

        rst = 1'b1; ren = 1'b0; rpc = 32'h0; rdy = 1'b0;
        #1;

        for (int i = 0; i < 22; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            rst = tv[i].rst; ren = tv[i].ren; rpc = tv[i].rpc; rdy = tv[i].rdy;
            step_and_check(tag);
            chk({tag, " tbl.valid"}, 32'(valid_a), 32'(tv[i].ev));
            chk({tag, " tbl.pc"},    ipc_a,        tv[i].eipc);
            chk({tag, " tbl.instr"}, instr_a,      tv[i].einstr);
            chk({tag, " tbl.addr"},  32'(addr_a),  tv[i].eaddr);
            chk({tag, " tbl.err"},   32'(err_a),   32'(tv[i].eerr));
            if (tv[i].cb) chk({tag, " tbl.wrap_pc"}, ipc_b, tv[i].ebpc);
        end

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            ren = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) rpc = $urandom;
            else                           rpc = 32'($urandom_range(0, 255)) * 4;
            step_and_check($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
